// File: rtl/fifo_reader.sv
// Purpose : assembles 32-bit words from four byte reads of an 8-entry FIFO, little-endian (first byte in [7:0]).
// Latency : one READ + one CHECK cycle per byte; word_valid rises the cycle after the fourth byte is captured.
// Backpressure: word_valid/word_word_ready handshake holds the word and stalls all FIFO reads until accepted.
//
// Ports: clk, rst (async, active-high); enable gates new read requests; fifo_ren/fifo_dout/fifo_error
//        form the FIFO read port (response one cycle after fifo_ren, error=1 means empty);
//        word_out/word_valid/word_ready is the output handshake; err_cnt counts empty reads (saturating).
// Optional: define FIFO_READER_CHECKSUM_EN to add word_csum (XOR of the four bytes of word_out).
module fifo_reader #(
    parameter int BACKOFF_CYCLES = 4   // idle cycles after an empty read, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        fifo_ren,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_error,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  err_cnt
`ifdef FIFO_READER_CHECKSUM_EN
    ,
    output logic [7:0]  word_csum
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CHECK   = 3'd2,
        BACKOFF = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam logic [3:0] BO_LOAD = 4'(BACKOFF_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] bo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // fifo_ren and word_valid decode straight from the state register, so
    // reset clears them at once without waiting for a clock edge.
    always_comb begin
        state_nxt  = state;
        fifo_ren   = 1'b0;
        word_valid = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = READ;
            end
            READ: begin
                fifo_ren  = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                // The read in flight always completes; enable only decides
                // whether another one follows.
                if (fifo_error)      state_nxt = BACKOFF;
                else if (idx == 2'd3) state_nxt = OUT;
                else if (enable)     state_nxt = READ;
                else                 state_nxt = IDLE;
            end
            BACKOFF: begin
                // Counter is loaded with BACKOFF_CYCLES on entry, so leaving when
                // it is about to reach zero gives exactly BACKOFF_CYCLES idle cycles.
                if (bo_cnt <= 4'd1) state_nxt = enable ? READ : IDLE;
            end
            OUT: begin
                word_valid = 1'b1;
                // Going straight to READ on acceptance keeps the best case at
                // one word per 9 cycles; with enable low we rest in IDLE.
                if (word_ready) state_nxt = enable ? READ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: FIFO response is looked at only in CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 2'd0;
            bo_cnt   <= 4'd0;
            word_out <= 32'd0;
            err_cnt  <= 8'd0;
        end else begin
            case (state)
                CHECK: begin
                    if (fifo_error) begin
                        bo_cnt <= BO_LOAD;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    end else begin
                        word_out[{idx, 3'b000} +: 8] <= fifo_dout;
                        idx <= idx + 2'd1;   // wraps to 0 after the fourth byte
                    end
                end
                BACKOFF: begin
                    if (bo_cnt != 4'd0) bo_cnt <= bo_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_READER_CHECKSUM_EN
    // Running XOR restarted at byte 0; since every byte lane of word_out is
    // rewritten per word, the final value is the XOR of the completed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_csum <= 8'd0;
        end else if (state == CHECK && !fifo_error) begin
            word_csum <= (idx == 2'd0) ? fifo_dout : (word_csum ^ fifo_dout);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: byte assembly, empty-read backoff, output
// stall, asynchronous reset mid-word and error-counter saturation.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_ren;
    logic [7:0]  fifo_dout = 8'hA5;
    logic        fifo_error = 1'b1;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [7:0]  err_cnt;
`ifdef FIFO_READER_CHECKSUM_EN
    logic [7:0]  word_csum;
`endif

    int checks = 0;
    int failures = 0;

    fifo_reader #(.BACKOFF_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .fifo_error (fifo_error),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .err_cnt    (err_cnt)
`ifdef FIFO_READER_CHECKSUM_EN
        ,
        .word_csum  (word_csum)
`endif
    );

    always #5 clk = ~clk;

    // FIFO stand-in: answers a request one cycle later. Outside a response it
    // drives error=1 and junk data, which the reader must ignore.
    logic [7:0] fq[$];
    int cyc = 0;
    int ren_cnt = 0;
    int last_ren = -100;
    int prev_ren = -100;

    always @(posedge clk) begin : fifo_model
        logic ren_s;
        cyc = cyc + 1;
        ren_s = fifo_ren;
        if (ren_s) begin
            ren_cnt  = ren_cnt + 1;
            prev_ren = last_ren;
            last_ren = cyc;
        end
        #1;
        if (ren_s && fq.size() > 0) begin
            fifo_dout  = fq.pop_front();
            fifo_error = 1'b0;
        end else begin
            fifo_dout  = 8'hA5;
            fifo_error = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!word_valid && n < maxc);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int r0;
        int r1;
        logic [31:0] w0;
        logic stable;
        logic saw_valid;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_fifo_ren",   32'(fifo_ren),   32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_out",   word_out,        32'd0);
        check("rst_err_cnt",    32'(err_cnt),    32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_ren", 32'(ren_cnt), 32'd0);

        // Four bytes available, downstream always ready
        fq = {8'h11, 8'h22, 8'h33, 8'h44};
        r0 = ren_cnt;
        enable = 1'b1;
        wait_valid(50, n);
        check("w1_valid",    32'(word_valid),   32'd1);
        check("w1_latency",  32'(n),            32'd9);
        check("w1_word",     word_out,          32'h44332211);
        check("w1_ren_cnt",  32'(ren_cnt - r0), 32'd4);
        check("w1_err_cnt",  32'(err_cnt),      32'd0);
`ifdef FIFO_READER_CHECKSUM_EN
        check("w1_csum",     32'(word_csum),    32'h44);
`endif
        enable = 1'b0;
        @(negedge clk);
        check("w1_valid_one_cycle", 32'(word_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("w1_no_extra_ren", 32'(ren_cnt - r0), 32'd4);

        // Empty FIFO: error, 4-cycle backoff, retry
        r0 = ren_cnt;
        saw_valid = 1'b0;
        enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (word_valid) saw_valid = 1'b1;
        end
        check("bo_ren_cnt",  32'(ren_cnt - r0),       32'd4);
        check("bo_spacing",  32'(last_ren - prev_ren), 32'd6);
        check("bo_err_cnt",  32'(err_cnt),            32'd3);
        check("bo_no_valid", 32'(saw_valid),          32'd0);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("bo_err_final",   32'(err_cnt),       32'd4);
        check("bo_idle_no_ren", 32'(ren_cnt - r0),  32'd4);

        // Two bytes now, two more later; downstream stalled
        pulse_reset();
        check("rst2_word_out", word_out,     32'd0);
        check("rst2_err_cnt",  32'(err_cnt), 32'd0);
        fq = {8'hAA, 8'hBB};
        r0 = ren_cnt;
        word_ready = 1'b0;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        fq.push_back(8'hCC);
        fq.push_back(8'hDD);
        wait_valid(100, n);
        check("sp_valid",       32'(word_valid),        32'd1);
        check("sp_word",        word_out,               32'hDDCCBBAA);
        check("sp_err_nonzero", 32'(err_cnt != 8'd0),   32'd1);
        check("sp_ren_total",   32'(ren_cnt - r0),      32'(4 + int'(err_cnt)));

        // Stall in OUT for 10 cycles with enable still high
        w0 = word_out;
        r1 = ren_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (word_out !== w0 || word_valid !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", 32'(stable),        32'd1);
        check("stall_no_ren", 32'(ren_cnt - r1),  32'd0);
        word_ready = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("stall_release", 32'(word_valid), 32'd0);

        // Asynchronous reset after two bytes captured
        pulse_reset();
        fq = {8'h11, 8'h22, 8'h33, 8'h44};
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_partial", word_out,      32'h00002211);
        check("mid_ren",     32'(fifo_ren), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fifo_ren",   32'(fifo_ren),   32'd0);
        check("arst_word_valid", 32'(word_valid), 32'd0);
        check("arst_word_out",   word_out,        32'd0);
        check("arst_err_cnt",    32'(err_cnt),    32'd0);
        fq.delete();
        fq = {8'h55, 8'h66, 8'h77, 8'h88};
        @(negedge clk);
        rst = 1'b0;
        wait_valid(50, n);
        check("arst_next_latency", 32'(n), 32'd9);
        check("arst_next_word",    word_out, 32'h88776655);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // 300 empty reads: counter saturates
        fq.delete();
        pulse_reset();
        r0 = ren_cnt;
        enable = 1'b1;
        n = 0;
        while ((ren_cnt - r0) < 300 && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("sat_reads_done", 32'((ren_cnt - r0) >= 300), 32'd1);
        repeat (3) @(negedge clk);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
